// File: rtl/gated_reduce_scan_pkg.sv
// Shared types and default constants for the gated reduce/scan block.
// Contents:
//   state_e      - scan FSM state (idle / scanning)
//   Def*         - default constant values for the top-level parameters
package gated_reduce_scan_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

  localparam logic [10:0] DefLoadVal   = 11'h09d;
  localparam logic [10:0] DefSelConst  = 11'h03e;
  localparam logic [10:0] DefThresh    = 11'h0ab;
  localparam logic [10:0] DefDefaultOut = 11'h570;

endpackage

// File: rtl/grs_channel_eval.sv
// Combinational reduce/compare/mux chain for one capture value.
// Ports:
//   cap    - capture register value being evaluated
//   gate_s - scan gate latched at scan start
//   res    - channel result
module grs_channel_eval #(
  parameter int unsigned      WIDTH       = 11,
  parameter int unsigned      GATE_HI     = 4,
  parameter int unsigned      GATE_LO     = 3,
  parameter logic [WIDTH-1:0] THRESH      = 11'h0ab,
  parameter logic [WIDTH-1:0] DEFAULT_OUT = 11'h570
) (
  input  logic [WIDTH-1:0] cap,
  input  logic             gate_s,
  output logic [WIDTH-1:0] res
);

  logic gate_c;
  logic cmp_c;

  assign gate_c = |cap[GATE_HI:GATE_LO];
  assign cmp_c  = (cap > THRESH);

  always_comb begin
    res = DEFAULT_OUT;
    if (gate_s) begin
      res = gate_c ? WIDTH'(cmp_c) : cap;
    end
  end

endmodule

// File: rtl/gated_reduce_scan.sv
// Multi-channel capture bank with a start-triggered scan that emits one
// gated result per channel on a valid/ready port; done marks the last beat.
// Ports:
//   clock_1, reset_1      - clock, asynchronous active-high reset
//   load_en, load_mode    - per-channel load strobe, 0: LOAD_VAL / 1: in_data
//   in_data, in_sel       - load data and scan-gate operand / operand select
//   start                 - scan request (ignored while busy)
//   out_ready             - consumer accept
//   out_valid, out_data,
//   out_ch, done          - result beat, channel index, last-channel flag
//   busy                  - scan in progress
module gated_reduce_scan
  import gated_reduce_scan_pkg::*;
#(
  parameter int unsigned      WIDTH       = 11,
  parameter int unsigned      CHANNELS    = 4,
  parameter int unsigned      GATE_HI     = 4,
  parameter int unsigned      GATE_LO     = 3,
  parameter logic [WIDTH-1:0] LOAD_VAL    = DefLoadVal,
  parameter logic [WIDTH-1:0] SEL_CONST   = DefSelConst,
  parameter logic [WIDTH-1:0] THRESH      = DefThresh,
  parameter logic [WIDTH-1:0] DEFAULT_OUT = DefDefaultOut
) (
  input  logic                        clock_1,
  input  logic                        reset_1,
  input  logic [CHANNELS-1:0]         load_en,
  input  logic                        load_mode,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_sel,
  input  logic                        start,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(CHANNELS)-1:0] out_ch,
  output logic                        done,
  output logic                        busy
);

  localparam int unsigned     ChW     = $clog2(CHANNELS);
  localparam logic [ChW-1:0] LastIdx = ChW'(CHANNELS - 1);

  logic [WIDTH-1:0] cap_q [CHANNELS];

  state_e           state_q, state_d;
  logic [ChW-1:0]   idx_q, idx_d;
  logic             gate_s_q, gate_s_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [ChW-1:0]   out_ch_q, out_ch_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] cap_sel;
  logic [WIDTH-1:0] res;
  logic             slot_free;

  // Capture bank: loads are accepted regardless of scan state.
  always_ff @(posedge clock_1 or posedge reset_1) begin
    if (reset_1) begin
      for (int c = 0; c < CHANNELS; c++) cap_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (load_en[c]) cap_q[c] <= load_mode ? in_data : LOAD_VAL;
      end
    end
  end

  // Single evaluator shared across channels via the idx mux.
  assign cap_sel = cap_q[idx_q];

  grs_channel_eval #(
    .WIDTH       (WIDTH),
    .GATE_HI     (GATE_HI),
    .GATE_LO     (GATE_LO),
    .THRESH      (THRESH),
    .DEFAULT_OUT (DEFAULT_OUT)
  ) u_eval (
    .cap    (cap_sel),
    .gate_s (gate_s_q),
    .res    (res)
  );

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gate_s_d    = gate_s_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    done_d      = done_q;

    // Accepted beat retires unless a new beat overwrites it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StScan;
          idx_d    = '0;
          busy_d   = 1'b1;
          gate_s_d = |(in_sel ? SEL_CONST : in_data);
        end
      end
      StScan: begin
        if (slot_free) begin
          out_data_d  = res;
          out_ch_d    = idx_q;
          out_valid_d = 1'b1;
          done_d      = (idx_q == LastIdx);
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_1 or posedge reset_1) begin
    if (reset_1) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      gate_s_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gate_s_q    <= gate_s_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gated_reduce_scan.sv
// Scoreboard bench for gated_reduce_scan: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_gated_reduce_scan;

  logic        clock_1;
  logic        reset_1;
  logic [3:0]  load_en;
  logic        load_mode;
  logic [10:0] in_data;
  logic        in_sel;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_data;
  logic [1:0]  out_ch;
  logic        done;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        done;
    logic [1:0]  ch;
    logic [10:0] data;
  } beat_t;

  beat_t exp_q[$];

  gated_reduce_scan dut (
    .clock_1   (clock_1),
    .reset_1   (reset_1),
    .load_en   (load_en),
    .load_mode (load_mode),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .done      (done),
    .busy      (busy)
  );

  initial clock_1 = 1'b0;
  always #5 clock_1 = ~clock_1;

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clock_1) begin
    if (!reset_1 && out_valid && out_ready) begin
      beat_t got;
      beat_t want;
      got = '{done: done, ch: out_ch, data: out_data};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got ch=%0d data=%h done=%0b, required no beat",
                 got.ch, got.data, got.done);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL beat: got ch=%0d data=%h done=%0b, required ch=%0d data=%h done=%0b",
                   got.ch, got.data, got.done, want.ch, want.data, want.done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push4(input logic [10:0] d0, input logic [10:0] d1,
                       input logic [10:0] d2, input logic [10:0] d3);
    exp_q.push_back('{done: 1'b0, ch: 2'd0, data: d0});
    exp_q.push_back('{done: 1'b0, ch: 2'd1, data: d1});
    exp_q.push_back('{done: 1'b0, ch: 2'd2, data: d2});
    exp_q.push_back('{done: 1'b1, ch: 2'd3, data: d3});
  endtask

  task automatic load_ch(input int c, input logic [10:0] val);
    load_mode = 1'b1;
    in_data   = val;
    load_en   = 4'b0001 << c;
    @(posedge clock_1); #1;
    load_en   = 4'b0000;
  endtask

  // Start is held across one edge (edge k); returns at k + 1 time unit.
  task automatic do_start(input logic sel, input logic [10:0] dat);
    in_sel  = sel;
    in_data = dat;
    start   = 1'b1;
    @(posedge clock_1); #1;
    start   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge clock_1); #1;
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL %s_drain: got pending=%0d busy=%0b, required pending=0 busy=0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clock_1); #1;
    chk({name, "_valid_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_1   = 1'b1;
    load_en   = 4'b0000;
    load_mode = 1'b0;
    in_data   = 11'h000;
    in_sel    = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_ch",    32'(out_ch),    32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    repeat (2) @(posedge clock_1);
    #1 reset_1 = 1'b0;

    // 1: ch0 <= LOAD_VAL (gate=1, 0x09d <= 0x0ab -> 0); others 0 pass through.
    load_mode = 1'b0;
    load_en   = 4'b0001;
    @(posedge clock_1); #1;
    load_en   = 4'b0000;
    push4(11'h000, 11'h000, 11'h000, 11'h000);
    do_start(1'b1, 11'h000);
    chk("t1_busy_k", 32'(busy), 32'd1);
    repeat (3) @(posedge clock_1);
    #1 chk("t1_busy_k3", 32'(busy), 32'd1);
    @(posedge clock_1);
    #1 chk("t1_busy_k4", 32'(busy), 32'd0);
    drain("t1");

    // 2: gated compare, gate-0 pass-through values.
    load_ch(1, 11'h0f0);
    load_ch(2, 11'h207);
    load_ch(3, 11'h0a0);
    push4(11'h000, 11'h001, 11'h207, 11'h0a0);
    do_start(1'b1, 11'h000);
    drain("t2");

    // 3: scan gate 0 -> DEFAULT_OUT on every channel.
    push4(11'h570, 11'h570, 11'h570, 11'h570);
    do_start(1'b0, 11'h000);
    drain("t3");

    // 4: stall on first beat, cap[0] changes and start pulses underneath.
    push4(11'h000, 11'h001, 11'h207, 11'h0a0);
    do_start(1'b1, 11'h000);
    out_ready = 1'b0;
    @(posedge clock_1); #1;
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_ch",    32'(out_ch),    32'd0);
    load_mode = 1'b1;
    in_data   = 11'h0f0;
    load_en   = 4'b0001;
    start     = 1'b1;
    @(posedge clock_1); #1;
    load_en   = 4'b0000;
    start     = 1'b0;
    chk("t4_data_s1", 32'(out_data), 32'h000);
    chk("t4_ch_s1",   32'(out_ch),   32'd0);
    chk("t4_done_s1", 32'(done),     32'd0);
    @(posedge clock_1); #1;
    chk("t4_data_s2", 32'(out_data), 32'h000);
    chk("t4_ch_s2",   32'(out_ch),   32'd0);
    chk("t4_busy_s2", 32'(busy),     32'd1);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clock_1); #1;
    start     = 1'b0;
    drain("t4");

    // 5: ch2 loaded on the edge it is sampled -> old value, then new on rescan.
    push4(11'h001, 11'h001, 11'h207, 11'h0a0);
    do_start(1'b1, 11'h000);
    @(posedge clock_1);
    @(posedge clock_1); #1;
    load_mode = 1'b1;
    in_data   = 11'h0f0;
    load_en   = 4'b0100;
    @(posedge clock_1); #1;
    load_en   = 4'b0000;
    drain("t5a");
    push4(11'h001, 11'h001, 11'h001, 11'h0a0);
    do_start(1'b1, 11'h000);
    drain("t5b");

    // 6: asynchronous reset mid-scan, then a clean rescan from ch0.
    push4(11'h001, 11'h001, 11'h001, 11'h0a0);
    do_start(1'b1, 11'h000);
    @(posedge clock_1);
    @(posedge clock_1);
    #3 reset_1 = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_done",  32'(done),      32'd0);
    chk("t6_busy",  32'(busy),      32'd0);
    chk("t6_data",  32'(out_data),  32'd0);
    exp_q.delete();
    #4 reset_1 = 1'b0;
    repeat (3) begin
      @(posedge clock_1); #1;
      chk("t6_quiet", 32'(out_valid), 32'd0);
    end
    push4(11'h570, 11'h570, 11'h570, 11'h570);
    do_start(1'b0, 11'h000);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
